// File: rtl/ahb_decoder_mux_if.sv
// AHB-Lite bus bundle between the manager/subordinate side and the address decoder/response mux.
// The "slave" modport is the decoder's view; "master" is the environment driving it.
interface ahb_decoder_mux_if #(
    parameter int ADDR_WIDTH         = 32,
    parameter int DATA_WIDTH         = 32,
    parameter int NO_OF_SUBORDINATES = 6
);
    logic [ADDR_WIDTH-1:0]                    HADDR;
    logic [1:0]                               HTRANS;
    logic [NO_OF_SUBORDINATES-1:0]            HSEL;
    logic [NO_OF_SUBORDINATES*DATA_WIDTH-1:0] HRDATA_S;
    logic [NO_OF_SUBORDINATES-1:0]            HREADYOUT_S;
    logic [NO_OF_SUBORDINATES-1:0]            HRESP_S;
    logic [DATA_WIDTH-1:0]                    HRDATA;
    logic                                     HREADY;
    logic                                     HRESP;
    logic [7:0]                               ERR_COUNT;

    modport slave (
        input  HADDR, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
        output HSEL, HRDATA, HREADY, HRESP, ERR_COUNT
    );

    modport master (
        output HADDR, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
        input  HSEL, HRDATA, HREADY, HRESP, ERR_COUNT
    );
endinterface

// File: rtl/ahb_decoder_mux.sv
// AHB-Lite address decoder with registered data-phase response mux and a built-in
// default subordinate that answers unmapped NONSEQ/SEQ transfers with a two-cycle ERROR.
module ahb_decoder_mux #(
    parameter int ADDR_WIDTH            = 32,
    parameter int DATA_WIDTH            = 32,
    parameter int NO_OF_SUBORDINATES    = 6,
    parameter int BITS_FOR_SUBORDINATES = 3
) (
    input logic              HCLK,
    input logic              HRESET,
    ahb_decoder_mux_if.slave bus
);
    localparam int N = NO_OF_SUBORDINATES;
    localparam int B = BITS_FOR_SUBORDINATES;

    localparam logic [1:0] DS_IDLE = 2'd0;
    localparam logic [1:0] DS_ERR1 = 2'd1;
    localparam logic [1:0] DS_ERR2 = 2'd2;

    localparam logic [N:0] SEL_DEFAULT = {1'b1, {N{1'b0}}};

    logic [B-1:0]          region;
    logic [N:0]            dec_sel;
    logic [N:0]            sel_q, sel_d;
    logic [1:0]            state_q, state_d;
    logic [7:0]            err_cnt_q, err_cnt_d;
    logic                  ds_ready, ds_resp;
    logic                  take_err;
    logic [DATA_WIDTH-1:0] mux_rdata;
    logic                  mux_ready, mux_resp;

    assign region = bus.HADDR[ADDR_WIDTH-1 -: B];

    // Bit N of the select vectors is the default subordinate.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        dec_sel = '0;
        for (int k = 0; k < N; k++) begin
            dec_sel[k] = (region == B'(k + 1));
        end
        dec_sel[N] = (region == '0) || (region > B'(N));
    end

    assign bus.HSEL = dec_sel[N-1:0];

    assign ds_ready = (state_q != DS_ERR1);
    assign ds_resp  = (state_q != DS_IDLE);

    // sel_q is one-hot, so an AND-OR mux is sufficient.
    always_comb begin
        mux_rdata = '0;
        mux_ready = sel_q[N] & ds_ready;
        mux_resp  = sel_q[N] & ds_resp;
        for (int k = 0; k < N; k++) begin
            mux_rdata = mux_rdata | ({DATA_WIDTH{sel_q[k]}} & bus.HRDATA_S[k*DATA_WIDTH +: DATA_WIDTH]);
            mux_ready = mux_ready | (sel_q[k] & bus.HREADYOUT_S[k]);
            mux_resp  = mux_resp  | (sel_q[k] & bus.HRESP_S[k]);
        end
    end

    assign bus.HRDATA    = mux_rdata;
    assign bus.HREADY    = mux_ready;
    assign bus.HRESP     = mux_resp;
    assign bus.ERR_COUNT = err_cnt_q;

    assign sel_d    = mux_ready ? dec_sel : sel_q;
    assign take_err = mux_ready & dec_sel[N] & bus.HTRANS[1];

    always_comb begin
        state_d = DS_IDLE;
        case (state_q)
            DS_IDLE, DS_ERR2: state_d = take_err ? DS_ERR1 : DS_IDLE;
            DS_ERR1:          state_d = DS_ERR2;
            default:          state_d = DS_IDLE;
        endcase
    end

    // Last cycle of any error response, from a subordinate or the default; saturates.
    assign err_cnt_d = (mux_ready && mux_resp && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sel_q     <= SEL_DEFAULT;
            state_q   <= DS_IDLE;
            err_cnt_q <= 8'd0;
        end else begin
            sel_q     <= sel_d;
            state_q   <= state_d;
            err_cnt_q <= err_cnt_d;
        end
    end
endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Directed self-checking bench for ahb_decoder_mux: decode, wait-state mux, default
// subordinate errors, counter saturation and reset during an error response.
module tb_ahb_decoder_mux;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int N  = 6;
    localparam int B  = 3;

    localparam logic [1:0] T_IDLE   = 2'd0;
    localparam logic [1:0] T_NONSEQ = 2'd2;

    logic HCLK = 1'b0;
    logic HRESET;
    int   checks = 0;
    int   errors = 0;

    ahb_decoder_mux_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NO_OF_SUBORDINATES(N)) bus ();

    ahb_decoder_mux #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .NO_OF_SUBORDINATES(N), .BITS_FOR_SUBORDINATES(B)
    ) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge, leaving room to drive inputs.
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic slice(input int k, input logic [DW-1:0] v);
        bus.HRDATA_S[k*DW +: DW] = v;
    endtask

    logic [N-1:0] exp_hsel [8];

    initial begin
        exp_hsel = '{6'h00, 6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h00};

        HRESET          = 1'b1;
        bus.HADDR       = 32'h2000_0000;
        bus.HTRANS      = T_IDLE;
        bus.HREADYOUT_S = '1;
        bus.HRESP_S     = '0;
        for (int k = 0; k < N; k++) slice(k, 32'hA000_0000 + DW'(k));

        // Reset
        tick();
        #1 check("hsel_in_reset", bus.HSEL, 6'h01);
        tick();
        #1;
        check("rst_hready", bus.HREADY, 1'b1);
        check("rst_hresp", bus.HRESP, 1'b0);
        check("rst_hrdata", bus.HRDATA, 32'h0);
        check("rst_errcnt", bus.ERR_COUNT, 8'd0);
        HRESET = 1'b0;

        // Decode sweep
        for (int r = 0; r < 8; r++) begin
            bus.HADDR = 32'(r) << 29;
            #1 check($sformatf("decode_r%0d", r), bus.HSEL, exp_hsel[r]);
        end
        tick();

        // Read via subordinate 2 with two wait states
        bus.HADDR          = 32'h6000_0004;
        bus.HTRANS         = T_NONSEQ;
        bus.HREADYOUT_S[2] = 1'b0;
        #1 check("rd_addr_hsel", bus.HSEL, 6'h04);
        check("rd_addr_hready", bus.HREADY, 1'b1);
        tick();
        bus.HADDR = 32'hA000_0000;
        #1 check("rd_wait1_hready", bus.HREADY, 1'b0);
        check("rd_wait1_hrdata", bus.HRDATA, 32'hA000_0002);
        tick();
        #1 check("rd_wait2_hready", bus.HREADY, 1'b0);
        check("rd_wait2_hrdata", bus.HRDATA, 32'hA000_0002);
        bus.HREADYOUT_S[2] = 1'b1;
        slice(2, 32'hCAFE_F00D);
        #1 check("rd_done_hready", bus.HREADY, 1'b1);
        check("rd_done_hrdata", bus.HRDATA, 32'hCAFE_F00D);
        check("rd_done_hresp", bus.HRESP, 1'b0);
        tick();
        bus.HADDR  = 32'h2000_0000;
        bus.HTRANS = T_IDLE;
        #1 check("rd_next_sub4", bus.HRDATA, 32'hA000_0004);
        tick();
        #1 check("rd_next_sub0", bus.HRDATA, 32'hA000_0000);

        // Subordinate 0 two-cycle ERROR passthrough
        bus.HRESP_S[0]     = 1'b1;
        bus.HREADYOUT_S[0] = 1'b0;
        #1 check("sub_err1_hready", bus.HREADY, 1'b0);
        check("sub_err1_hresp", bus.HRESP, 1'b1);
        tick();
        bus.HREADYOUT_S[0] = 1'b1;
        #1 check("sub_err2_hready", bus.HREADY, 1'b1);
        check("sub_err2_hresp", bus.HRESP, 1'b1);
        check("sub_err2_cnt", bus.ERR_COUNT, 8'd0);
        tick();
        bus.HRESP_S[0] = 1'b0;
        #1 check("sub_err_cnt", bus.ERR_COUNT, 8'd1);

        // Unmapped NONSEQ
        bus.HADDR  = 32'hE000_0000;
        bus.HTRANS = T_NONSEQ;
        #1 check("unm_hsel", bus.HSEL, 6'h00);
        tick();
        bus.HTRANS = T_IDLE;
        #1 check("unm_err1_hready", bus.HREADY, 1'b0);
        check("unm_err1_hresp", bus.HRESP, 1'b1);
        tick();
        #1 check("unm_err2_hready", bus.HREADY, 1'b1);
        check("unm_err2_hresp", bus.HRESP, 1'b1);
        check("unm_err2_cnt", bus.ERR_COUNT, 8'd1);
        tick();
        #1 check("unm_done_cnt", bus.ERR_COUNT, 8'd2);
        check("idle_unm_hready", bus.HREADY, 1'b1);
        check("idle_unm_hresp", bus.HRESP, 1'b0);
        tick();
        #1 check("idle_unm_cnt", bus.ERR_COUNT, 8'd2);
        check("idle_unm_hresp2", bus.HRESP, 1'b0);

        // Back-to-back unmapped NONSEQ to region 0
        bus.HADDR  = 32'h0000_0000;
        bus.HTRANS = T_NONSEQ;
        tick();
        #1 check("b2b_err1_hready", bus.HREADY, 1'b0);
        tick();
        #1 check("b2b_err2_hready", bus.HREADY, 1'b1);
        check("b2b_err2_hresp", bus.HRESP, 1'b1);
        tick();
        #1 check("b2b_reenter_hready", bus.HREADY, 1'b0);
        check("b2b_reenter_hresp", bus.HRESP, 1'b1);
        check("b2b_cnt", bus.ERR_COUNT, 8'd3);

        // Saturation: each pair of cycles completes one more error
        for (int i = 0; i < 250; i++) begin tick(); tick(); end
        #1 check("sat_cnt_253", bus.ERR_COUNT, 8'd253);
        tick(); tick();
        #1 check("sat_cnt_254", bus.ERR_COUNT, 8'd254);
        tick(); tick();
        #1 check("sat_cnt_255", bus.ERR_COUNT, 8'd255);
        for (int i = 0; i < 96; i++) begin tick(); tick(); end
        #1 check("sat_cnt_hold", bus.ERR_COUNT, 8'd255);

        // Reset during DS_ERR1
        HRESET     = 1'b1;
        bus.HTRANS = T_IDLE;
        tick();
        HRESET     = 1'b0;
        bus.HADDR  = 32'hE000_0000;
        bus.HTRANS = T_NONSEQ;
        tick();
        bus.HTRANS = T_IDLE;
        #1 check("mid_err1_hready", bus.HREADY, 1'b0);
        HRESET = 1'b1;
        tick();
        #1 check("mid_rst_hready", bus.HREADY, 1'b1);
        check("mid_rst_hresp", bus.HRESP, 1'b0);
        HRESET = 1'b0;
        tick();
        #1 check("mid_rst_cnt", bus.ERR_COUNT, 8'd0);

        // Reset coinciding with the completing DS_ERR2 cycle
        bus.HTRANS = T_NONSEQ;
        tick();
        bus.HTRANS = T_IDLE;
        tick();
        #1 check("sim_err2_hresp", bus.HRESP, 1'b1);
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        #1 check("sim_rst_cnt", bus.ERR_COUNT, 8'd0);
        check("sim_rst_hresp", bus.HRESP, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
